// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 32-entry x 32-bit integer register file for the RV32I core.
// It has two combinational read ports for decode and one synchronous write
// port for writeback. x0 is hardwired to zero.
//
// Ports:
//   clk           system clock; all state changes on the rising edge
//   rst           synchronous active-high reset; clears every register
//   RegWEn        write enable for the write port
//   ReadReg1      read port 1 register index
//   ReadReg2      read port 2 register index
//   WriteReg      write port register index
//   RegWriteData  write data
//   RegReadData1  contents of register ReadReg1 (0 for x0)
//   RegReadData2  contents of register ReadReg2 (0 for x0)
// -----------------------------------------------------------------------------
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWEn,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] RegWriteData,
  output logic [DATA_WIDTH-1:0] RegReadData1,
  output logic [DATA_WIDTH-1:0] RegReadData2
);

  localparam int Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic [DATA_WIDTH-1:0] regs_d [Depth];

  // Next-state for the storage array. Only one entry can change per cycle.
  // Writes to index 0 are dropped here, so x0 keeps its reset value of zero.
  always_comb begin
    regs_d = regs_q;
    if (RegWEn && (WriteReg != '0)) begin
      regs_d[WriteReg] = RegWriteData;
    end
  end

  // Storage update. Reset takes priority over a write in the same cycle, and
  // it also clears x0, so the whole array is defined after the first reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational reads with no write bypass. A same-cycle write shows up
  // only after the edge. Index 0 is forced to zero here as well as being
  // write-protected, so a read of x0 never depends on the array contents.
  assign RegReadData1 = (ReadReg1 == '0) ? '0 : regs_q[ReadReg1];
  assign RegReadData2 = (ReadReg2 == '0) ? '0 : regs_q[ReadReg2];

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
// Self-checking bench for reg_file. It runs the directed scenarios first and
// then a randomized phase checked against a simple array model of the
// architectural registers.
// -----------------------------------------------------------------------------
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        RegWEn;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  WriteReg;
  logic [31:0] RegWriteData;
  logic [31:0] RegReadData1;
  logic [31:0] RegReadData2;

  int compareCount = 0;
  int failCount    = 0;

  // Architectural view of the register file. x0 is always zero.
  logic [31:0] model [32];

  reg_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWEn      (RegWEn),
    .ReadReg1    (ReadReg1),
    .ReadReg2    (ReadReg2),
    .WriteReg    (WriteReg),
    .RegWriteData(RegWriteData),
    .RegReadData1(RegReadData1),
    .RegReadData2(RegReadData2)
  );

  // 20 ns clock period.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Every comparison goes through this task. It counts the comparison and
  // reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Expected read value for an index, taken from the model.
  function automatic logic [31:0] expectRead(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : model[idx];
  endfunction

  // Advance one rising edge and apply the architectural effect of the inputs
  // held across that edge. Then settle 1 ns so checks happen away from the edge.
  task automatic applyStimulus();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (RegWEn && WriteReg != 5'd0) begin
      model[WriteReg] = RegWriteData;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1; RegWEn = 1'b0; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    WriteReg = 5'd0; RegWriteData = 32'h0;
    #1;

    // Reset for 5 cycles, then sweep all indices.
    repeat (5) applyStimulus();
    checkOutput("reset_rd1", RegReadData1, 32'h0);
    checkOutput("reset_rd2", RegReadData2, 32'h0);
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      ReadReg1 = 5'(i);
      #1;
      checkOutput("reset_sweep", RegReadData1, 32'h0);
    end

    // Basic write then read.
    RegWEn = 1'b1; WriteReg = 5'd5; RegWriteData = 32'hA5A5A5A5;
    repeat (2) applyStimulus();
    RegWEn = 1'b0; ReadReg1 = 5'd5;
    #1;
    checkOutput("basic_x5", RegReadData1, 32'hA5A5A5A5);

    // x0 write protection.
    RegWEn = 1'b1; WriteReg = 5'd0; RegWriteData = 32'hA5A5A5A5;
    repeat (2) applyStimulus();
    RegWEn = 1'b0; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    #1;
    checkOutput("x0_rd1", RegReadData1, 32'h0);
    checkOutput("x0_rd2", RegReadData2, 32'h0);

    // Dual read.
    RegWEn = 1'b1; WriteReg = 5'd10; RegWriteData = 32'hDCDCDCDC;
    applyStimulus();
    RegWEn = 1'b0;
    repeat (5) applyStimulus();
    ReadReg1 = 5'd5; ReadReg2 = 5'd10;
    #1;
    checkOutput("dual_x5", RegReadData1, 32'hA5A5A5A5);
    checkOutput("dual_x10", RegReadData2, 32'hDCDCDCDC);

    // Write disable.
    RegWEn = 1'b0; WriteReg = 5'd5; RegWriteData = 32'hFFFFFFFF;
    repeat (3) applyStimulus();
    checkOutput("wdis_x5", RegReadData1, 32'hA5A5A5A5);

    // Read during write: the old value is visible before the edge.
    ReadReg1 = 5'd7; ReadReg2 = 5'd7;
    RegWEn = 1'b1; WriteReg = 5'd7; RegWriteData = 32'h12345678;
    #1;
    checkOutput("rdw_before", RegReadData1, 32'h0);
    applyStimulus();
    checkOutput("rdw_after", RegReadData1, 32'h12345678);
    checkOutput("rdw_after_p2", RegReadData2, 32'h12345678);

    // Reset wins over a write at the same edge.
    rst = 1'b1; RegWEn = 1'b1; WriteReg = 5'd7; RegWriteData = 32'hDEADBEEF;
    applyStimulus();
    rst = 1'b0; RegWEn = 1'b0; ReadReg2 = 5'd5;
    #1;
    checkOutput("rstprio_x7", RegReadData1, 32'h0);
    checkOutput("rstprio_x5", RegReadData2, 32'h0);

    // Randomized traffic checked against the model, both before each edge
    // (pre-write values) and after it.
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 39) == 0);
      RegWEn       = $urandom_range(0, 1);
      WriteReg     = 5'($urandom_range(0, 31));
      RegWriteData = $urandom;
      ReadReg1     = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
      ReadReg2     = ($urandom_range(0, 3) == 0) ? ReadReg1 : 5'($urandom_range(0, 31));
      #1;
      checkOutput("rand_pre_rd1", RegReadData1, expectRead(ReadReg1));
      checkOutput("rand_pre_rd2", RegReadData2, expectRead(ReadReg2));
      applyStimulus();
      checkOutput("rand_post_rd1", RegReadData1, expectRead(ReadReg1));
      checkOutput("rand_post_rd2", RegReadData2, expectRead(ReadReg2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 32-bit general-purpose integer register file for the RV32I CPU core.
- Two asynchronous (combinational) read ports serve the decode stage. One synchronous write port serves the writeback stage.
- Register x0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32: width of each register and of the data ports.
- ADDR_WIDTH, 5: register index width; depth is 2**ADDR_WIDTH (32 entries).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- RegWEn  input  1  write enable for the write port.
- ReadReg1  input  ADDR_WIDTH  read port 1 register index.
- ReadReg2  input  ADDR_WIDTH  read port 2 register index.
- WriteReg  input  ADDR_WIDTH  write port register index.
- RegWriteData  input  DATA_WIDTH  write data.
- RegReadData1  output  DATA_WIDTH  contents of register ReadReg1.
- RegReadData2  output  DATA_WIDTH  contents of register ReadReg2.

Behaviour:
- Storage: registers x0..x31, each DATA_WIDTH bits.
- Reset:
  - When rst=1 at a rising clk edge, all registers (x1..x31) are cleared to 0.
  - rst has priority over RegWEn; no write occurs in a reset cycle.
  - Reset is synchronous: asserting rst between edges has no effect until the next edge.
- Write:
  - At a rising clk edge with rst=0 and RegWEn=1, register[WriteReg] <= RegWriteData.
  - With RegWEn=0, no register changes.
- x0:
  - Writes to index 0 are discarded regardless of RegWEn and data.
  - Reads of index 0 always return 0.
- Read:
  - Purely combinational, zero latency.
  - RegReadData1 = (ReadReg1==0) ? 0 : register[ReadReg1]. RegReadData2 is formed the same way from ReadReg2.
  - Outputs track index changes within the same cycle.
- Read-during-write, same index:
  - Reads return the value stored before the edge.
  - The newly written value appears on the outputs immediately after the rising edge that performs the write.
  - There is no internal write-to-read bypass; forwarding belongs to the pipeline.
- Both read ports may address the same register, or the write index, simultaneously, with no conflict.
- Outputs after reset: both read 0 for any index.
- No X propagation: every register has a defined value after the first reset edge.

Test Plan:
- Reset: hold rst=1 for 5 clk cycles (20 ns period), ReadReg1=ReadReg2=0, RegWEn=0 -> RegReadData1=RegReadData2=0x00000000. Then sweep ReadReg1 over 1..31 -> all 0.
- Basic write/read: rst=0, RegWEn=1, WriteReg=5, RegWriteData=0xA5A5A5A5 for 2 edges; then RegWEn=0 and ReadReg1=5 -> RegReadData1=0xA5A5A5A5.
- x0 protection: RegWEn=1, WriteReg=0, RegWriteData=0xA5A5A5A5 for 2 edges; ReadReg1=0, ReadReg2=0 -> both read 0x00000000.
- Dual read: write x10=0xDCDCDCDC, then RegWEn=0 for 5 cycles; ReadReg1=5, ReadReg2=10 -> RegReadData1=0xA5A5A5A5, RegReadData2=0xDCDCDCDC.
- Write disable: with RegWEn=0, drive WriteReg=5 and RegWriteData=0xFFFFFFFF for 3 edges -> x5 still reads 0xA5A5A5A5.
- Read-during-write and reset priority, in order:
  - Hold ReadReg1=7 and write x7=0x12345678 -> RegReadData1 stays at the old value (0) before the edge and reads 0x12345678 after it.
  - Assert rst=1 with RegWEn=1, WriteReg=7, RegWriteData=0xDEADBEEF at the same edge -> x7 reads 0 after that edge.
